dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the 256 x 16-bit dual-domain data memory. Each word holds {Domain1[15:8], Domain2[7:0]}. The arbiter shares the memory's single read/write port between the core load/store path (port C) and a host/debug loader (port H). Core has priority; a starvation counter guarantees H forward progress. Read data is registered and returned with a one-cycle valid pulse to the winning requester.

## Interface
- MAX_WAIT, 4, consecutive cycles H may be denied before it is forced a grant; legal 1..15
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low
- c_req  in  1  core request, level, held until c_gnt
- c_we  in  1  core store (1) / load (0)
- c_addr  in  8  core word address
- c_wdata  in  16  core store data {D1,D2}
- c_gnt  out  1  core granted this cycle (combinational)
- c_rvalid  out  1  core load data valid (registered)
- c_rdata  out  16  core load data (registered)
- h_req, h_we, h_addr[7:0], h_wdata[15:0]  in  host equivalents of the core inputs
- h_gnt  out  1  host granted this cycle (combinational)
- h_rvalid  out  1  host load data valid (registered)
- h_rdata  out  16  host load data (registered)
- mem_rd_addr  out  8  to memory read address
- mem_wr_addr  out  8  to memory write address
- mem_wr_data  out  16  to memory write data
- mem_store  out  1  to memory write enable
- mem_rd_data  in  16  memory combinational read data

## Operation
- FSM states: NORMAL, HOST_URGENT. Reset: NORMAL, wait_cnt=0.
- Grant, NORMAL: c_req wins. h_gnt only when h_req && !c_req.
- Grant, HOST_URGENT: h_req wins. c_gnt only when c_req && !h_req.
- At most one grant per cycle. No grant while rst_n=0.
- wait_cnt (4-bit) counts cycles with h_req=1 && h_gnt=0. It clears on any cycle with h_gnt=1 or h_req=0.
- NORMAL -> HOST_URGENT when wait_cnt reaches MAX_WAIT, evaluated on the edge where the increment produces MAX_WAIT.
- HOST_URGENT -> NORMAL on the edge following h_gnt=1, or if h_req drops.
- Memory drive (combinational from the winner):
  - mem_rd_addr = mem_wr_addr = winner addr.
  - mem_wr_data = winner wdata.
  - mem_store = winner we && grant.
  - With no grant: mem_store=0 and addresses/data=0.
- Load: on the grant edge, capture mem_rd_data into the winner's rdata and set its rvalid=1 for exactly the next cycle. rdata holds its value until the next load to the same port.
- Store: no rvalid. Memory writes on the grant edge.
- Both domains always move as a 16-bit pair; the arbiter never splits or modifies data.

## Timing
- Grant latency: 0 cycles when uncontended (gnt same cycle as req).
- Load latency: rvalid/rdata asserted the cycle after gnt.
- Back-to-back: one access per cycle, fully pipelined; a requester holding req gets consecutive grants unless preempted.
- Store then load, same address, consecutive cycles: the load returns the new data, because the write commits on the earlier edge.
- Worst-case H wait under continuous c_req: MAX_WAIT cycles, then granted on cycle MAX_WAIT+1.
- Reset values: c_rvalid=h_rvalid=0, c_rdata=h_rdata=16'h0000, gnts=0, mem_store=0.
- Reset mid-operation: any pending rvalid is cancelled and wait_cnt cleared; no memory write occurs in a reset cycle.
- Dropping req without a grant is legal; the request is simply withdrawn with no side effect.

## Test plan
- Uncontended load: memory[8'h10]=16'hA55A, c_req load addr 8'h10 -> c_gnt same cycle, next cycle c_rvalid=1 and c_rdata=16'hA55A; h_rvalid stays 0.
- Store-then-load: H stores 16'h1234 to 8'hFF, then loads 8'hFF next cycle -> h_rdata=16'h1234 with h_rvalid one cycle after the second grant.
- Contention and starvation (MAX_WAIT=4):
  - Stimulus: c_req and h_req held high continuously.
  - Expected: C granted 4 cycles, H granted on the 5th, pattern repeats.
  - Expected: no cycle has both grants.
- Simultaneous drop: in HOST_URGENT, h_req falls before grant -> state returns NORMAL, c_gnt=1 that cycle, wait_cnt=0.
- Reset mid-load: assert rst_n=0 on the edge after c_gnt -> c_rvalid=0, c_rdata=0, mem_store=0 throughout reset; memory contents unchanged.
- Address extremes: stores to 8'h00 and 8'hFF with distinct data, read back via both ports -> each returns its own data, with no wrap or aliasing.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single read/write port of the 256 x 16-bit dual-domain data
// memory between the core load/store path (port C) and a host/debug loader
// (port H). Each word is {Domain1[15:8], Domain2[7:0]} and always moves as a
// complete 16-bit pair. The arbiter never splits or modifies it.
//
// The core normally has priority. If H is denied MAX_WAIT cycles in a row,
// the arbiter enters HOST_URGENT for one cycle, and H wins that cycle.
//
// Ports
//   clk, rst_n                  clock and synchronous active-low reset
//   c_req/c_we/c_addr/c_wdata   core request: level, store/load, address, data
//   c_gnt                       core granted this cycle (combinational)
//   c_rvalid/c_rdata            core load result, one cycle after the grant
//   h_req/h_we/h_addr/h_wdata   host request (same meaning as the core inputs)
//   h_gnt                       host granted this cycle (combinational)
//   h_rvalid/h_rdata            host load result, one cycle after the grant
//   mem_rd_addr/mem_wr_addr     memory addresses, both driven by the winner
//   mem_wr_data/mem_store       memory write data and write enable
//   mem_rd_data                 combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4  // legal 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [7:0]  c_addr,
  input  logic [15:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [15:0] c_rdata,
  input  logic        h_req,
  input  logic        h_we,
  input  logic [7:0]  h_addr,
  input  logic [15:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [15:0] h_rdata,
  output logic [7:0]  mem_rd_addr,
  output logic [7:0]  mem_wr_addr,
  output logic [15:0] mem_wr_data,
  output logic        mem_store,
  input  logic [15:0] mem_rd_data
);

  typedef enum logic [0:0] {
    NORMAL      = 1'b0,
    HOST_URGENT = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_nxt;
  logic [7:0]  win_addr;

  // Grants depend on the current requests, so the winner can access the
  // memory in the same cycle that it requests.
  always_comb begin
    // NOTE: every signal written here gets a default first. Without the
    // defaults, a path that skips an assignment would infer a latch.
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (rst_n) begin
      if (state == HOST_URGENT) begin
        h_gnt = h_req;
        c_gnt = c_req && !h_req;
      end else begin
        c_gnt = c_req;
        h_gnt = h_req && !c_req;
      end
    end
  end

  // Winner mux. The bus is all zeros when nobody is granted, so an idle
  // cycle never presents stale address or data to the memory.
  always_comb begin
    win_addr    = 8'h00;
    mem_wr_data = 16'h0000;
    mem_store   = 1'b0;
    if (h_gnt) begin
      win_addr    = h_addr;
      mem_wr_data = h_wdata;
      mem_store   = h_we;
    end else if (c_gnt) begin
      win_addr    = c_addr;
      mem_wr_data = c_wdata;
      mem_store   = c_we;
    end
  end

  assign mem_rd_addr = win_addr;
  assign mem_wr_addr = win_addr;

  // Count consecutive cycles in which H is asking and losing.
  assign wait_nxt = (h_req && !h_gnt) ? wait_cnt + 4'd1 : 4'd0;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments. Every register
    // therefore samples values from before the edge, whatever the order of
    // the statements.
    if (!rst_n) begin
      state    <= NORMAL;
      wait_cnt <= 4'd0;
      c_rvalid <= 1'b0;
      h_rvalid <= 1'b0;
      // NOTE: the read-data holding registers are reset so that a port
      // reads 0 until its first load. The 256-word array is outside this
      // block and is not touched by reset.
      c_rdata  <= 16'h0000;
      h_rdata  <= 16'h0000;
    end else begin
      wait_cnt <= wait_nxt;

      case (state)
        NORMAL:      if (wait_nxt == MAX_WAIT_CNT) state <= HOST_URGENT;
        HOST_URGENT: if (h_gnt || !h_req)          state <= NORMAL;
        default:                                   state <= NORMAL;
      endcase

      // A load captures the memory's combinational read data on the grant
      // edge. A store commits on the same edge, so a following load to the
      // same address returns the new data.
      c_rvalid <= c_gnt && !c_we;
      h_rvalid <= h_gnt && !h_we;
      if (c_gnt && !c_we) c_rdata <= mem_rd_data;
      if (h_gnt && !h_we) h_rdata <= mem_rd_data;
    end
  end

endmodule
